// File: rtl/mux_8bit_pkg.sv
// -----------------------------------------------------------------------------
// mux_8bit_pkg
//   Shared constants for the mux_8bit datapath selector.
//   - MUX_WIDTH : default data width of the selector and its register stage.
//   - SEL_A/B   : encoding of the select input (0 steers A, 1 steers B).
//   - sel_e     : enum view of the same encoding for readable comparisons.
// -----------------------------------------------------------------------------
package mux_8bit_pkg;

  localparam int unsigned MUX_WIDTH = 8;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic {
    SEL_IS_A = SEL_A,
    SEL_IS_B = SEL_B
  } sel_e;

endpackage : mux_8bit_pkg

// File: rtl/mux_8bit_mux2_comb.sv
// -----------------------------------------------------------------------------
// mux2_comb
//   Parameterized, purely combinational 2:1 selector.
//   Ports:
//     a   [WIDTH-1:0] in   data returned when sel = SEL_A
//     b   [WIDTH-1:0] in   data returned when sel = SEL_B
//     sel             in   select line
//     y   [WIDTH-1:0] out  sel ? b : a
//   An X/Z select is deliberately not masked; the result is then undefined.
// -----------------------------------------------------------------------------
module mux2_comb
  import mux_8bit_pkg::*;
#(
  parameter int unsigned WIDTH = MUX_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = (sel_e'(sel) == SEL_IS_B) ? b : a;

endmodule : mux2_comb

// File: rtl/mux_8bit.sv
// -----------------------------------------------------------------------------
// mux_8bit
//   Two-input data selector with a zero-latency output and a one-cycle
//   registered, valid-qualified copy.
//   Ports:
//     clk        in               rising-edge clock
//     rst_n      in               asynchronous reset, active low
//     A          in  [WIDTH-1:0]  data input 0 (select = 0)
//     B          in  [WIDTH-1:0]  data input 1 (select = 1)
//     select     in               0 -> A, 1 -> B
//     in_valid   in               qualifies A/B/select for the register stage
//     Y          out [WIDTH-1:0]  combinational select ? B : A
//     Y_q        out [WIDTH-1:0]  registered result, loaded when in_valid = 1
//     out_valid  out              high the cycle after an in_valid cycle
//   Y is not affected by reset; only the register stage is.
// -----------------------------------------------------------------------------
module mux_8bit
  import mux_8bit_pkg::*;
#(
  parameter int unsigned      WIDTH     = MUX_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             select,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_q,
  output logic             out_valid
);

  // Single selector instance: the same result drives Y and the register input,
  // so both paths are guaranteed to agree.
  logic [WIDTH-1:0] sel_data;

  mux2_comb #(
    .WIDTH (WIDTH)
  ) u_mux2 (
    .a   (A),
    .b   (B),
    .sel (select),
    .y   (sel_data)
  );

  assign Y = sel_data;

  // Register stage.
  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;

  always_comb begin
    // NOTE: defaults first so every path assigns every signal -- no latch.
    data_d  = data_q;
    valid_d = 1'b0;
    if (in_valid) begin
      data_d  = sel_data;
      valid_d = 1'b1;
    end
  end

  // NOTE: non-blocking assignments for flops; blocking here would create
  // order-dependent simulation races between always_ff blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= RESET_VAL;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign Y_q       = data_q;
  assign out_valid = valid_q;

endmodule : mux_8bit

// File: tb/tb_mux_8bit.sv
// -----------------------------------------------------------------------------
// tb_mux_8bit
//   Self-checking bench for mux_8bit. A behavioural reference (expected
//   selection plus a one-entry "last valid result" and a valid flag) predicts
//   Y, Y_q and out_valid for directed and randomized stimulus.
// -----------------------------------------------------------------------------
module tb_mux_8bit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a, b;
  logic         sel;
  logic         in_valid;
  logic [W-1:0] y, y_q;
  logic         out_valid;

  int checks = 0;
  int errors = 0;

  // Reference state: what Y_q / out_valid should show right now.
  logic [W-1:0] exp_yq;
  logic         exp_ov;
  int           ov_count;

  mux_8bit #(
    .WIDTH     (W),
    .RESET_VAL (8'h00)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (a),
    .B         (b),
    .select    (sel),
    .in_valid  (in_valid),
    .Y         (y),
    .Y_q       (y_q),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pick(input logic [W-1:0] da, input logic [W-1:0] db,
                                        input logic s);
    return s ? db : da;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [W-1:0] da, input logic [W-1:0] db, input logic s,
                        input logic v);
    a = da; b = db; sel = s; in_valid = v;
  endtask

  // One cycle: inputs driven at negedge, Y checked, then edge and register
  // outputs checked against the reference just after it.
  task automatic step(input string tag, input logic [W-1:0] da, input logic [W-1:0] db,
                      input logic s, input logic v);
    set_in(da, db, s, v);
    #1;
    check({tag, "_y"}, y, pick(da, db, s));
    @(posedge clk);
    if (rst_n) begin
      if (v) exp_yq = pick(da, db, s);
      exp_ov = v;
    end
    #1;
    check({tag, "_yq"}, y_q, exp_yq);
    check({tag, "_ov"}, out_valid, exp_ov);
    if (out_valid) ov_count++;
    @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    exp_yq = '0;
    exp_ov = 1'b0;
    set_in(8'd0, 8'd0, 1'b0, 1'b0);

    // Reset values before any clock edge.
    #2;
    check("rst_yq", y_q, 32'h00);
    check("rst_ov", out_valid, 32'h0);

    // Combinational vectors, no clock edge between them.
    set_in(8'd216, 8'd20, 1'b1, 1'b0);  #0.5; check("comb0", y, 32'd20);
    set_in(8'd63, 8'd202, 1'b0, 1'b0);  #0.5; check("comb1", y, 32'd63);
    set_in(8'd231, 8'd185, 1'b1, 1'b0); #0.5; check("comb2", y, 32'd185);
    set_in(8'd229, 8'd84, 1'b0, 1'b0);  #0.5; check("comb3", y, 32'd229);

    @(negedge clk);
    rst_n = 1'b1;

    // Single capture then hold.
    step("cap", 8'd63, 8'd202, 1'b0, 1'b1);
    check("cap_const", y_q, 32'd63);
    step("hold", 8'd1, 8'd2, 1'b1, 1'b0);
    check("hold_const", y_q, 32'd63);

    // Four back-to-back valid cycles.
    ov_count = 0;
    step("b2b0", 8'd216, 8'd20, 1'b1, 1'b1);
    check("b2b0_const", y_q, 32'd20);
    step("b2b1", 8'd63, 8'd202, 1'b0, 1'b1);
    check("b2b1_const", y_q, 32'd63);
    step("b2b2", 8'd231, 8'd185, 1'b1, 1'b1);
    check("b2b2_const", y_q, 32'd185);
    step("b2b3", 8'd229, 8'd84, 1'b0, 1'b1);
    check("b2b3_const", y_q, 32'd229);
    step("b2b_idle", 8'd0, 8'd0, 1'b0, 1'b0);
    check("b2b_pulses", ov_count, 32'd4);

    // Asynchronous reset mid-stream.
    step("pre_rst", 8'd231, 8'd185, 1'b1, 1'b1);
    check("pre_rst_const", y_q, 32'd185);
    set_in(8'd231, 8'd185, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_yq = '0;
    exp_ov = 1'b0;
    check("async_yq", y_q, 32'h00);
    check("async_ov", out_valid, 32'h0);
    set_in(8'd5, 8'd9, 1'b1, 1'b1);
    #1;
    check("rst_y_tracks", y, 32'd9);
    @(negedge clk);
    step("in_rst", 8'd5, 8'd9, 1'b1, 1'b1);
    rst_n = 1'b1;
    step("post_rst", 8'd0, 8'd0, 1'b0, 1'b0);

    // Boundary values, toggling select.
    for (int i = 0; i < 6; i++) begin
      step("bound", 8'hFF, 8'h00, 1'(i), 1'b1);
      check("bound_const", y_q, (i % 2 == 0) ? 32'hFF : 32'h00);
    end

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst_n  = 1'b0;
        #1;
        exp_yq = '0;
        exp_ov = 1'b0;
        check("rnd_rst_yq", y_q, 32'h00);
        check("rnd_rst_ov", out_valid, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
      end
      step("rnd", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mux_8bit

// File: doc/mux_8bit.md
Name: mux_8bit

Overview:
- Two-input, WIDTH-bit (default 8) data selector. Provides a combinational output and a registered, valid-qualified copy.
- Used as a generic datapath steering element. Downstream logic uses either the zero-latency path Y or the one-cycle registered path Y_q.
- One clock domain; asynchronous active-low reset.

Parameters:
- WIDTH, 8: data width of A, B, Y, Y_q.
- RESET_VAL, 0: value loaded into Y_q on reset (WIDTH bits).

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- A  input  WIDTH  data input 0, selected when select=0.
- B  input  WIDTH  data input 1, selected when select=1.
- select  input  1  0 selects A, 1 selects B.
- in_valid  input  1  qualifies A/B/select for the registered path.
- Y  output  WIDTH  combinational result: select ? B : A.
- Y_q  output  WIDTH  registered result, loaded when in_valid=1.
- out_valid  output  1  high the cycle after a cycle with in_valid=1.

Behaviour:
- Y is purely combinational, zero latency: Y = (select==1) ? B : A.
  - Changes on A, B or select propagate with no clock.
  - Y is independent of clk, rst_n and in_valid, and is not forced during reset.
- select is X or Z: Y is undefined. No X-masking logic is added.
- Registered path, rising edge of clk with rst_n=1:
  - in_valid=1: Y_q <= (select ? B : A); out_valid <= 1.
  - in_valid=0: Y_q holds its value; out_valid <= 0.
- Latency A/B/select to Y_q is one cycle. No backpressure; every valid input produces exactly one out_valid pulse.
- Reset (rst_n=0): asynchronous assertion.
  - Y_q = RESET_VAL and out_valid = 0 immediately, without waiting for a clock.
  - Both hold while rst_n=0.
  - Reset mid-stream drops any pending result.
- Reset release: synchronous use. The first capture happens on the first rising edge with rst_n=1 and in_valid=1.
- Back-to-back valid inputs:
  - out_valid stays high continuously.
  - Y_q updates every cycle.
- No arithmetic. Widths of A, B, Y, Y_q are identical; no truncation or extension.

Decomposition:
- Shared package: WIDTH default constant and the select encoding constants SEL_A=1'b0, SEL_B=1'b1.
- One sub-module, mux2_comb: parameterized pure combinational 2:1 selector. Instantiated once; its output feeds both Y and the Y_q register.
- The register stage stays in the top module.

Test Plan:
- A=216, B=20, select=1 -> Y=20 immediately.
  - A=63, B=202, select=0 -> Y=63.
  - A=231, B=185, select=1 -> Y=185.
  - A=229, B=84, select=0 -> Y=229.
  - All checks made with no clock edge between changes.
- in_valid=1 with A=63, B=202, select=0, then clock edge -> Y_q=63, out_valid=1. Next edge with in_valid=0 -> Y_q stays 63, out_valid=0.
- Four consecutive valid cycles using the four vectors above -> Y_q sequence 20, 63, 185, 229 one cycle delayed; out_valid high for exactly 4 cycles.
- Assert rst_n=0 between clock edges while Y_q=185, out_valid=1:
  - Y_q=0 and out_valid=0 before the next edge.
  - Y still tracks inputs (e.g. A=5, B=9, select=1 -> Y=9).
- Boundary values:
  - A=8'hFF, B=8'h00, toggle select each cycle -> Y alternates FF/00.
  - With in_valid=1, Y_q follows one cycle later.
